// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus port between instruction fetch (IF) and
// load/store (MEM). One bus transaction at a time, one-cycle completion pulse per
// requester, bounded IF starvation and a timeout for unresponsive bus cycles.
module mem_arbiter #(
    parameter int unsigned MEM_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // instruction fetch requester
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ack,
    output logic        o_if_err,
    // load/store requester
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_sel,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_ack,
    output logic        o_mem_err,
    // shared bus
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_sel,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack,
    // pipeline stall requests
    output logic        o_stallreq_if,
    output logic        o_stallreq_mem
);

    localparam logic [3:0] StreakMax = 4'(MEM_STREAK_MAX);
    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyMem
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_streak, w_streak_nxt;
    logic [7:0]  r_timer, w_timer_nxt;

    logic        r_bus_req, w_bus_req_nxt;
    logic        r_bus_we, w_bus_we_nxt;
    logic [31:0] r_bus_addr, w_bus_addr_nxt;
    logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
    logic [3:0]  r_bus_sel, w_bus_sel_nxt;

    logic        r_if_ack, w_if_ack_nxt;
    logic        r_if_err, w_if_err_nxt;
    logic [31:0] r_if_rdata, w_if_rdata_nxt;
    logic        r_mem_ack, w_mem_ack_nxt;
    logic        r_mem_err, w_mem_err_nxt;
    logic [31:0] r_mem_rdata, w_mem_rdata_nxt;

    // A requester is ignored in its own ack cycle: its request line is still
    // high there because it only sees the ack in that same cycle.
    logic w_if_req_ok, w_mem_req_ok, w_mem_wins, w_finish, w_abort;

    assign w_if_req_ok  = i_if_req & ~r_if_ack;
    assign w_mem_req_ok = i_mem_req & ~r_mem_ack;
    assign w_mem_wins   = w_mem_req_ok & ~(w_if_req_ok & (r_streak == StreakMax));
    assign w_abort      = ~i_bus_ack & (r_timer == TimerLast);
    assign w_finish     = i_bus_ack | w_abort;

    // Next-state: arbitration in idle, completion or timeout while busy.
    always_comb begin
        w_state_nxt     = r_state;
        w_streak_nxt    = r_streak;
        w_timer_nxt     = r_timer;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_bus_sel_nxt   = r_bus_sel;
        w_if_ack_nxt    = 1'b0;
        w_if_err_nxt    = 1'b0;
        w_if_rdata_nxt  = 32'h0;
        w_mem_ack_nxt   = 1'b0;
        w_mem_err_nxt   = 1'b0;
        w_mem_rdata_nxt = 32'h0;

        unique case (r_state)
            StIdle: begin
                w_bus_req_nxt   = 1'b0;
                w_bus_we_nxt    = 1'b0;
                w_bus_addr_nxt  = 32'h0;
                w_bus_wdata_nxt = 32'h0;
                w_bus_sel_nxt   = 4'h0;
                if (w_mem_wins) begin
                    w_state_nxt     = StBusyMem;
                    w_timer_nxt     = 8'h0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = i_mem_we;
                    w_bus_addr_nxt  = i_mem_addr;
                    w_bus_wdata_nxt = i_mem_wdata;
                    w_bus_sel_nxt   = i_mem_sel;
                    if (!w_if_req_ok) begin
                        w_streak_nxt = 4'h0;
                    end else if (r_streak >= StreakMax) begin
                        w_streak_nxt = StreakMax;
                    end else begin
                        w_streak_nxt = r_streak + 4'h1;
                    end
                end else if (w_if_req_ok) begin
                    w_state_nxt     = StBusyIf;
                    w_timer_nxt     = 8'h0;
                    w_streak_nxt    = 4'h0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_addr_nxt  = i_if_addr;
                    w_bus_wdata_nxt = 32'h0;
                    w_bus_sel_nxt   = 4'hF;
                end
            end
            StBusyIf, StBusyMem: begin
                if (w_finish) begin
                    w_state_nxt     = StIdle;
                    w_bus_req_nxt   = 1'b0;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_addr_nxt  = 32'h0;
                    w_bus_wdata_nxt = 32'h0;
                    w_bus_sel_nxt   = 4'h0;
                    if (r_state == StBusyIf) begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_err_nxt   = w_abort;
                        w_if_rdata_nxt = i_bus_ack ? i_bus_rdata : 32'h0;
                    end else begin
                        w_mem_ack_nxt   = 1'b1;
                        w_mem_err_nxt   = w_abort;
                        // Stores return zero data to the requester.
                        w_mem_rdata_nxt = (i_bus_ack && !r_bus_we) ? i_bus_rdata : 32'h0;
                    end
                end else begin
                    w_timer_nxt = r_timer + 8'h1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_streak    <= 4'h0;
            r_timer     <= 8'h0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_bus_sel   <= 4'h0;
            r_if_ack    <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_mem_ack   <= 1'b0;
            r_mem_err   <= 1'b0;
            r_mem_rdata <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_streak    <= w_streak_nxt;
            r_timer     <= w_timer_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_if_err    <= w_if_err_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_mem_ack   <= w_mem_ack_nxt;
            r_mem_err   <= w_mem_err_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
        end
    end

    assign o_bus_req      = r_bus_req;
    assign o_bus_we       = r_bus_we;
    assign o_bus_addr     = r_bus_addr;
    assign o_bus_wdata    = r_bus_wdata;
    assign o_bus_sel      = r_bus_sel;
    assign o_if_ack       = r_if_ack;
    assign o_if_err       = r_if_err;
    assign o_if_rdata     = r_if_rdata;
    assign o_mem_ack      = r_mem_ack;
    assign o_mem_err      = r_mem_err;
    assign o_mem_rdata    = r_mem_rdata;
    assign o_stallreq_if  = i_if_req & ~r_if_ack;
    assign o_stallreq_mem = i_mem_req & ~r_mem_ack;

endmodule
